// File: rtl/mem_1024x8_sp_arbiter_if.sv
// Requester A/B request buses plus the single-port RAM port of mem_1024x8_sp_arbiter.
// slave = arbiter side; master = requesters and RAM side.
interface mem_1024x8_sp_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              a_req;
  logic              a_wen;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_wen;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_d_in;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_d_out;
  logic              busy;

  modport slave (
    input  a_req, a_wen, a_addr, a_wdata,
    input  b_req, b_wen, b_addr, b_wdata,
    input  mem_d_out,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_addr, mem_d_in, mem_wen, busy
  );

  modport master (
    output a_req, a_wen, a_addr, a_wdata,
    output b_req, b_wen, b_addr, b_wdata,
    output mem_d_out,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_addr, mem_d_in, mem_wen, busy
  );
endinterface

// File: rtl/mem_1024x8_sp_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// Optional post-reset zero-fill sweep is enabled by defining MEM_ARB_CLEAR_EN.
module mem_1024x8_sp_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic reset,
  mem_1024x8_sp_arbiter_if.slave bus
);

  // Handshake: x_req is held until x_gnt; x_gnt is combinational and the RAM
  // access happens in that same cycle. A read grant is answered by a one-cycle
  // x_rvalid pulse in the following cycle with x_rdata taken from the RAM.
  logic              prio_b;
  logic              clearing;
  logic [ADDR_W-1:0] sweep_addr;
  logic              a_gnt;
  logic              b_gnt;
  logic              a_rvalid;
  logic              b_rvalid;

`ifdef MEM_ARB_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] count_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    if (state == CLEAR) begin
      count_next = count + 1'b1;
      if (count == {ADDR_W{1'b1}}) state_next = RUN;
    end
  end

  assign clearing   = (state == CLEAR);
  assign sweep_addr = count;
`else
  assign clearing   = 1'b0;
  assign sweep_addr = '0;
`endif

  always_comb begin
    a_gnt        = 1'b0;
    b_gnt        = 1'b0;
    bus.mem_addr = '0;
    bus.mem_d_in = '0;
    bus.mem_wen  = 1'b0;
    if (!reset) begin
      if (clearing) begin
        bus.mem_addr = sweep_addr;
        bus.mem_wen  = 1'b1;
      end else if (bus.a_req && (!bus.b_req || !prio_b)) begin
        a_gnt        = 1'b1;
        bus.mem_addr = bus.a_addr;
        bus.mem_d_in = bus.a_wdata;
        bus.mem_wen  = bus.a_wen;
      end else if (bus.b_req) begin
        b_gnt        = 1'b1;
        bus.mem_addr = bus.b_addr;
        bus.mem_d_in = bus.b_wdata;
        bus.mem_wen  = bus.b_wen;
      end
    end
  end

  // Priority always passes to the side that was not just served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_b   <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_gnt & ~bus.a_wen;
      b_rvalid <= b_gnt & ~bus.b_wen;
      if (a_gnt)      prio_b <= 1'b1;
      else if (b_gnt) prio_b <= 1'b0;
    end
  end

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.a_rvalid = a_rvalid;
  assign bus.b_rvalid = b_rvalid;
  assign bus.a_rdata  = bus.mem_d_out;
  assign bus.b_rdata  = bus.mem_d_out;
  assign bus.busy     = clearing;

endmodule

// File: tb/tb_mem_1024x8_sp_arbiter.sv
// Bench for mem_1024x8_sp_arbiter: RAM fixture, arbitration/memory reference model,
// directed scenario tasks and a randomized run. Define MEM_ARB_CLEAR_EN for sweep scenarios.
module tb_mem_1024x8_sp_arbiter;
  localparam int DEPTH = 1024;
`ifdef MEM_ARB_CLEAR_EN
  localparam int SWEEP_LEN = DEPTH;
`else
  localparam int SWEEP_LEN = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passed = 0;

  mem_1024x8_sp_arbiter_if bus ();
  mem_1024x8_sp_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // RAM fixture; contents are stored inverted so unwritten words read as 0xFF.
  bit [7:0] ram_n [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_wen) ram_n[bus.mem_addr] <= ~bus.mem_d_in;
    bus.mem_d_out <= ~ram_n[bus.mem_addr];
  end

  // Reference model state
  logic [7:0] ref_mem [DEPTH];
  logic       fav_b;
  logic       pend_a, pend_b;
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  int         sweep_left;

  logic       e_a_gnt, e_b_gnt, e_a_rv, e_b_rv, e_wen, e_busy;
  logic [9:0] e_addr;
  logic [7:0] e_din, e_a_data, e_b_data;

  logic       o_a_gnt, o_b_gnt, o_a_rv, o_b_rv, o_wen, o_busy;
  logic [9:0] o_addr;
  logic [7:0] o_din, o_a_rdata, o_b_rdata;

  // Drives one cycle, computes expectations, snapshots outputs, then advances to posedge+1.
  task automatic apply(input logic ar, input logic aw, input logic [9:0] aa, input logic [7:0] ad,
                       input logic br, input logic bw, input logic [9:0] ba, input logic [7:0] bd);
    bus.a_req = ar; bus.a_wen = aw; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_req = br; bus.b_wen = bw; bus.b_addr = ba; bus.b_wdata = bd;
    #3;
    e_a_rv = pend_a && !reset;
    e_b_rv = pend_b && !reset;
    e_a_data = 8'h00;
    e_b_data = 8'h00;
    if (e_a_rv && exp_q_a.size() > 0) e_a_data = exp_q_a.pop_front();
    if (e_b_rv && exp_q_b.size() > 0) e_b_data = exp_q_b.pop_front();
    e_a_gnt = 1'b0; e_b_gnt = 1'b0; e_wen = 1'b0; e_addr = 10'h0; e_din = 8'h00; e_busy = 1'b0;
    pend_a = 1'b0; pend_b = 1'b0;
    if (reset) begin
      fav_b = 1'b0;
      exp_q_a.delete();
      exp_q_b.delete();
    end else if (sweep_left > 0) begin
      e_busy = 1'b1;
      e_addr = 10'(DEPTH - sweep_left);
      e_wen  = 1'b1;
      ref_mem[e_addr] = 8'h00;
      sweep_left--;
    end else begin
      if (ar && (!br || !fav_b)) e_a_gnt = 1'b1;
      else if (br)               e_b_gnt = 1'b1;
      if (e_a_gnt) begin
        e_addr = aa; e_wen = aw; e_din = ad; fav_b = 1'b1;
        if (aw) ref_mem[aa] = ad;
        else begin pend_a = 1'b1; exp_q_a.push_back(ref_mem[aa]); end
      end
      if (e_b_gnt) begin
        e_addr = ba; e_wen = bw; e_din = bd; fav_b = 1'b0;
        if (bw) ref_mem[ba] = bd;
        else begin pend_b = 1'b1; exp_q_b.push_back(ref_mem[ba]); end
      end
    end
    o_a_gnt = bus.a_gnt; o_b_gnt = bus.b_gnt; o_a_rv = bus.a_rvalid; o_b_rv = bus.b_rvalid;
    o_wen = bus.mem_wen; o_busy = bus.busy; o_addr = bus.mem_addr; o_din = bus.mem_d_in;
    o_a_rdata = bus.a_rdata; o_b_rdata = bus.b_rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 10'h0, 8'h00, 1'b0, 1'b0, 10'h0, 8'h00);
  endtask

  task automatic release_reset();
    reset = 1'b0;
    sweep_left = SWEEP_LEN;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b1, 10'h3, 8'h11, 1'b1, 1'b1, 10'h4, 8'h22);
      checks++; if (o_a_gnt !== 1'b0) $display("FAIL reset_a_gnt: got %b want 0", o_a_gnt); else passed++;
      checks++; if (o_b_gnt !== 1'b0) $display("FAIL reset_b_gnt: got %b want 0", o_b_gnt); else passed++;
      checks++; if (o_wen !== 1'b0) $display("FAIL reset_mem_wen: got %b want 0", o_wen); else passed++;
      checks++; if ({o_a_rv, o_b_rv} !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", {o_a_rv, o_b_rv}); else passed++;
    end
    release_reset();
  endtask

  task automatic test_first_grant();
    apply(1'b1, 1'b0, 10'h3FF, 8'h00, 1'b1, 1'b0, 10'h001, 8'h00);
    checks++; if (o_busy !== 1'b0) $display("FAIL first_busy: got %b want 0", o_busy); else passed++;
    checks++; if ({o_a_gnt, o_b_gnt} !== 2'b10) $display("FAIL first_gnt: got %b want 10", {o_a_gnt, o_b_gnt}); else passed++;
    idle();
    checks++; if (o_a_rv !== 1'b1) $display("FAIL first_a_rvalid: got %b want 1", o_a_rv); else passed++;
    checks++; if (o_a_rdata !== 8'hFF) $display("FAIL first_a_rdata: got %h want ff", o_a_rdata); else passed++;
  endtask

  task automatic test_clear_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b1, 1'b0, 10'h3FF, 8'h00, 1'b1, 1'b0, 10'h001, 8'h00);
      checks++; if (o_busy !== 1'b1) $display("FAIL sweep_busy[%0d]: got %b want 1", i, o_busy); else passed++;
      checks++; if (o_wen !== 1'b1) $display("FAIL sweep_wen[%0d]: got %b want 1", i, o_wen); else passed++;
      checks++; if (o_addr !== 10'(i)) $display("FAIL sweep_addr[%0d]: got %h want %h", i, o_addr, 10'(i)); else passed++;
      checks++; if (o_din !== 8'h00) $display("FAIL sweep_din[%0d]: got %h want 00", i, o_din); else passed++;
      checks++; if ({o_a_gnt, o_b_gnt} !== 2'b00) $display("FAIL sweep_gnt[%0d]: got %b want 00", i, {o_a_gnt, o_b_gnt}); else passed++;
    end
    apply(1'b1, 1'b0, 10'h3FF, 8'h00, 1'b0, 1'b0, 10'h0, 8'h00);
    checks++; if (o_busy !== 1'b0) $display("FAIL sweep_end_busy: got %b want 0", o_busy); else passed++;
    checks++; if (o_a_gnt !== 1'b1) $display("FAIL sweep_end_a_gnt: got %b want 1", o_a_gnt); else passed++;
    idle();
    checks++; if (o_a_rv !== 1'b1) $display("FAIL sweep_read_rvalid: got %b want 1", o_a_rv); else passed++;
    checks++; if (o_a_rdata !== 8'h00) $display("FAIL sweep_read_rdata: got %h want 00", o_a_rdata); else passed++;
  endtask

  task automatic test_write_read();
    apply(1'b1, 1'b1, 10'h123, 8'h5A, 1'b0, 1'b0, 10'h0, 8'h00);
    checks++; if (o_a_gnt !== 1'b1) $display("FAIL wr_a_gnt: got %b want 1", o_a_gnt); else passed++;
    checks++; if ({o_wen, o_addr, o_din} !== {1'b1, 10'h123, 8'h5A})
      $display("FAIL wr_mem_port: got %b/%h/%h want 1/123/5a", o_wen, o_addr, o_din); else passed++;
    apply(1'b0, 1'b0, 10'h0, 8'h00, 1'b1, 1'b0, 10'h123, 8'h00);
    checks++; if ({o_a_gnt, o_b_gnt} !== 2'b01) $display("FAIL rd_b_gnt: got %b want 01", {o_a_gnt, o_b_gnt}); else passed++;
    checks++; if (o_wen !== 1'b0) $display("FAIL rd_mem_wen: got %b want 0", o_wen); else passed++;
    idle();
    checks++; if (o_b_rv !== 1'b1) $display("FAIL rd_b_rvalid: got %b want 1", o_b_rv); else passed++;
    checks++; if (o_b_rdata !== 8'h5A) $display("FAIL rd_b_rdata: got %h want 5a", o_b_rdata); else passed++;
    checks++; if (o_a_rv !== 1'b0) $display("FAIL rd_a_rvalid: got %b want 0", o_a_rv); else passed++;
    idle();
    checks++; if (o_b_rv !== 1'b0) $display("FAIL rd_b_rvalid_pulse: got %b want 0", o_b_rv); else passed++;
    checks++; if ({o_wen, o_addr, o_din} !== 19'h0) $display("FAIL idle_mem_port: got %b/%h/%h want 0/000/00", o_wen, o_addr, o_din); else passed++;
  endtask

  task automatic test_back_to_back();
    logic want_a;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) apply(1'b1, 1'b0, 10'(16 + i), 8'h00, 1'b1, 1'b0, 10'h123, 8'h00);
      else       idle();
      want_a = (i % 2 == 0);
      if (i < 6) begin
        checks++; if ({o_a_gnt, o_b_gnt} !== {want_a, !want_a})
          $display("FAIL b2b_gnt[%0d]: got %b want %b", i, {o_a_gnt, o_b_gnt}, {want_a, !want_a}); else passed++;
      end
      if (i > 0) begin
        checks++; if ({o_a_rv, o_b_rv} !== {!want_a, want_a})
          $display("FAIL b2b_rvalid[%0d]: got %b want %b", i, {o_a_rv, o_b_rv}, {!want_a, want_a}); else passed++;
        if (want_a) begin
          checks++; if (o_b_rdata !== 8'h5A) $display("FAIL b2b_b_rdata[%0d]: got %h want 5a", i, o_b_rdata); else passed++;
        end else begin
          checks++; if (o_a_rdata !== e_a_data) $display("FAIL b2b_a_rdata[%0d]: got %h want %h", i, o_a_rdata, e_a_data); else passed++;
        end
      end
    end
  endtask

  task automatic test_only_b();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 10'h0, 8'h00, 1'b1, 1'b0, 10'(i), 8'h00);
      checks++; if ({o_a_gnt, o_b_gnt} !== 2'b01) $display("FAIL only_b_gnt[%0d]: got %b want 01", i, {o_a_gnt, o_b_gnt}); else passed++;
    end
    apply(1'b1, 1'b0, 10'h5, 8'h00, 1'b1, 1'b0, 10'h6, 8'h00);
    checks++; if ({o_a_gnt, o_b_gnt} !== 2'b10) $display("FAIL only_b_then_both: got %b want 10", {o_a_gnt, o_b_gnt}); else passed++;
  endtask

  task automatic test_reset_mid_read();
    apply(1'b1, 1'b0, 10'h123, 8'h00, 1'b0, 1'b0, 10'h0, 8'h00);
    checks++; if (o_a_gnt !== 1'b1) $display("FAIL midrd_a_gnt: got %b want 1", o_a_gnt); else passed++;
    reset = 1'b1;
    idle();
    checks++; if (o_a_rv !== 1'b0) $display("FAIL midrd_a_rvalid: got %b want 0", o_a_rv); else passed++;
    release_reset();
    while (sweep_left > 0) idle();
    apply(1'b1, 1'b0, 10'h7, 8'h00, 1'b1, 1'b0, 10'h8, 8'h00);
    checks++; if ({o_a_gnt, o_b_gnt} !== 2'b10) $display("FAIL midrd_prio_a: got %b want 10", {o_a_gnt, o_b_gnt}); else passed++;
    idle();
    checks++; if (o_a_rv !== 1'b1) $display("FAIL midrd_next_rvalid: got %b want 1", o_a_rv); else passed++;
  endtask

  task automatic test_reset_mid_clear();
    int  n;
    logic done;
    reset = 1'b1;
    idle();
    release_reset();
    for (int i = 0; i < 'h200; i++) idle();
    idle();
    checks++; if ({o_wen, o_addr} !== {1'b1, 10'h200}) $display("FAIL midclr_at_200: got %b/%h want 1/200", o_wen, o_addr); else passed++;
    reset = 1'b1;
    idle();
    checks++; if (o_wen !== 1'b0) $display("FAIL midclr_reset_wen: got %b want 0", o_wen); else passed++;
    release_reset();
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 1100 && !done; i++) begin
      idle();
      if (o_busy === 1'b1) begin
        checks++; if (o_addr !== 10'(n)) $display("FAIL midclr_addr[%0d]: got %h want %h", n, o_addr, 10'(n)); else passed++;
        n++;
      end else done = 1'b1;
    end
    checks++; if (n != DEPTH) $display("FAIL midclr_busy_len: got %0d want %0d", n, DEPTH); else passed++;
  endtask

  task automatic test_random();
    logic ar, aw, br, bw;
    logic [9:0] aa, ba;
    logic [7:0] ad, bd;
    for (int i = 0; i < 300; i++) begin
      ar = 1'($urandom_range(0, 1)); aw = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1)); bw = 1'($urandom_range(0, 1));
      aa = 10'($urandom_range(0, 15)); ba = 10'($urandom_range(0, 15));
      ad = 8'($urandom_range(0, 255)); bd = 8'($urandom_range(0, 255));
      apply(ar, aw, aa, ad, br, bw, ba, bd);
      checks++; if ({o_a_gnt, o_b_gnt} !== {e_a_gnt, e_b_gnt})
        $display("FAIL rand_gnt[%0d]: got %b want %b", i, {o_a_gnt, o_b_gnt}, {e_a_gnt, e_b_gnt}); else passed++;
      checks++; if ({o_wen, o_addr, o_din} !== {e_wen, e_addr, e_din})
        $display("FAIL rand_mem_port[%0d]: got %b/%h/%h want %b/%h/%h", i, o_wen, o_addr, o_din, e_wen, e_addr, e_din); else passed++;
      checks++; if ({o_a_rv, o_b_rv} !== {e_a_rv, e_b_rv})
        $display("FAIL rand_rvalid[%0d]: got %b want %b", i, {o_a_rv, o_b_rv}, {e_a_rv, e_b_rv}); else passed++;
      checks++; if (o_busy !== e_busy) $display("FAIL rand_busy[%0d]: got %b want %b", i, o_busy, e_busy); else passed++;
      if (e_a_rv) begin
        checks++; if (o_a_rdata !== e_a_data) $display("FAIL rand_a_rdata[%0d]: got %h want %h", i, o_a_rdata, e_a_data); else passed++;
      end
      if (e_b_rv) begin
        checks++; if (o_b_rdata !== e_b_data) $display("FAIL rand_b_rdata[%0d]: got %h want %h", i, o_b_rdata, e_b_data); else passed++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hFF;
    fav_b = 1'b0; pend_a = 1'b0; pend_b = 1'b0; sweep_left = 0;
    bus.a_req = 1'b0; bus.a_wen = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_wen = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    @(posedge clk);
    #1;
    test_reset();
`ifdef MEM_ARB_CLEAR_EN
    test_clear_sweep();
`else
    test_first_grant();
`endif
    test_write_read();
    test_back_to_back();
    test_only_b();
    test_reset_mid_read();
`ifdef MEM_ARB_CLEAR_EN
    test_reset_mid_clear();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passed, checks);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_1024x8_sp_arbiter.md
MEM_1024X8_SP_ARBITER -- requirements
Module: mem_1024x8_sp_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have port clk, input, 1, single clock for all state; memory clocks on the same edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports a_req / b_req, input, 1, requester A/B access request, held until granted.
REQ-006 SHALL have ports a_wen / b_wen, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have ports a_addr / b_addr, input, ADDR_W, access address.
REQ-008 SHALL have ports a_wdata / b_wdata, input, DATA_W, write data.
REQ-009 SHALL have ports a_gnt / b_gnt, output, 1, combinational grant; the access executes this cycle.
REQ-010 SHALL have ports a_rvalid / b_rvalid, output, 1, read data valid.
REQ-011 SHALL have ports a_rdata / b_rdata, output, DATA_W, read data; both driven from mem_d_out.
REQ-012 SHALL have ports mem_addr, mem_d_in, mem_wen, output, ADDR_W/DATA_W/1, drive the single-port RAM addr, d_in and wen.
REQ-013 SHALL have port mem_d_out, input, DATA_W, RAM read data, valid one clk after the address is presented.
REQ-014 SHALL have port busy, output, 1, high while the post-reset clear sweep runs.

Function
REQ-015 SHALL grant at most one requester per cycle; a_gnt and b_gnt are never both 1.
REQ-016 SHALL grant the sole active requester when only one of a_req/b_req is high, regardless of priority.
REQ-017 SHALL resolve simultaneous requests round-robin via a 1-bit priority register: favoured side wins; after any grant, priority moves to the non-granted side.
REQ-018 SHALL, on a grant, drive mem_addr/mem_d_in from the granted side, with mem_wen = granted side's wen.
REQ-019 SHALL, with no grant, drive mem_wen = 0, mem_addr = 0, mem_d_in = 0.
REQ-020 SHALL assert x_rvalid exactly one cycle after a read grant to side x, for one cycle; writes produce no rvalid.
REQ-021 SHALL allow back-to-back grants every cycle; sustained dual requests alternate A,B,A,B with no idle cycles.
REQ-022 SHALL make a read after a write to the same address, in the next cycle, return the new data (RAM ordering, no forwarding).

Reset
REQ-023 SHALL, while reset = 1, force gnts, rvalids and mem_wen to 0 and set priority to A.
REQ-024 SHALL drop any pending rvalid when reset asserts mid-operation; the read is lost, not replayed.
REQ-025 SHALL, when reset asserts during the clear sweep, restart the sweep at address 0 on release.

Configuration
REQ-026 SHALL compile in, under macro MEM_ARB_CLEAR_EN, a two-state FSM CLEAR -> RUN with an ADDR_W-bit sweep counter.
REQ-027 SHALL, with MEM_ARB_CLEAR_EN defined, enter CLEAR on reset release with counter = 0.
REQ-028 SHALL, in CLEAR, drive mem_addr = counter, mem_d_in = 0, mem_wen = 1, busy = 1 and grants = 0, incrementing the counter each cycle.
REQ-029 SHALL go to RUN after the cycle writing address 2^ADDR_W-1; busy drops on the following cycle; the sweep lasts 1024 cycles at defaults.
REQ-030 SHALL, without MEM_ARB_CLEAR_EN, have no FSM or counter, tie busy to 0, and grant from the first cycle after reset.

Verification
REQ-031 SHALL cover: reset release with MEM_ARB_CLEAR_EN -> busy = 1 for 1024 cycles, mem_wen = 1 at addresses 0..1023 with data 0x00, then A read of 0x3FF -> a_rdata = 0x00.
REQ-032 SHALL cover: A writes 0x5A to 0x123, next cycle B reads 0x123 -> b_gnt = 1, b_rvalid = 1 one cycle later, b_rdata = 0x5A, a_rvalid stays 0.
REQ-033 SHALL cover: A and B both hold reads for 6 cycles -> grants A,B,A,B,A,B with no gaps; each rvalid is one cycle after its grant.
REQ-034 SHALL cover: only B requests for 3 cycles after a B grant -> b_gnt = 1 every cycle; next simultaneous request grants A.
REQ-035 SHALL cover: reset at clear-sweep address 0x200 -> on release the sweep restarts at 0x000, busy high for a full 1024 cycles.
REQ-036 SHALL cover: reset one cycle after an A read grant -> a_rvalid = 0, and the next simultaneous request after release grants A.
